// File: rtl/seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_display_ctrl
// Description : Registered multi-digit seven-segment controller with hex/glyph
//               decode, tick-driven blink and scroll. Optional leading-zero
//               blanking in hex mode is enabled by defining SEG7_LZB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 25_000_000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   din,
    input  logic                      glyph_mode,
    input  logic                      blink,
    input  logic                      scroll,
    output logic [7*NUM_DIGITS-1:0]   hex_leds,
    output logic                      tick
);

    localparam int                 c_cnt_w   = $clog2(TICK_DIV);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_tick;
    logic                    r_phase;
    logic                    r_valid;
    logic [4*NUM_DIGITS-1:0] r_buf;
    logic [7*NUM_DIGITS-1:0] r_leds;
    logic [4*NUM_DIGITS-1:0] w_rot;
    logic [7*NUM_DIGITS-1:0] w_dec;

    function automatic logic [6:0] hex_dec(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Codes A..F map to the letters y, i, n, -, P and a blank digit.
    function automatic logic [6:0] glyph_dec(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'hA:    seg = 7'h11;
            4'hB:    seg = 7'h7B;
            4'hC:    seg = 7'h2B;
            4'hD:    seg = 7'h3F;
            4'hE:    seg = 7'h0C;
            4'hF:    seg = 7'h7F;
            default: seg = hex_dec(code);
        endcase
        return seg;
    endfunction

    generate
        if (NUM_DIGITS == 1) begin : g_rot_single
            assign w_rot = r_buf;
        end else begin : g_rot_multi
            assign w_rot = {r_buf[4*NUM_DIGITS-5:0], r_buf[4*NUM_DIGITS-1 -: 4]};
        end
    endgenerate

`ifdef SEG7_LZB_EN
    // w_zero_from[i] is set when digits i..NUM_DIGITS-1 are all zero.
    logic [NUM_DIGITS:1] w_zero_from;
    assign w_zero_from[NUM_DIGITS] = 1'b1;
`endif

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            logic [3:0] w_code;
            logic       w_blank;
            assign w_code = r_buf[4*i +: 4];
`ifdef SEG7_LZB_EN
            if (i == 0) begin : g_lsd
                assign w_blank = 1'b0;
            end else begin : g_upper
                if (i < NUM_DIGITS - 1) begin : g_chain
                    assign w_zero_from[i] = w_zero_from[i+1] & (w_code == 4'h0);
                end else begin : g_top
                    assign w_zero_from[i] = (w_code == 4'h0);
                end
                assign w_blank = ~glyph_mode & w_zero_from[i];
            end
`else
            assign w_blank = 1'b0;
`endif
            assign w_dec[7*i +: 7] = w_blank    ? 7'h7F :
                                     glyph_mode ? glyph_dec(w_code) : hex_dec(w_code);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == c_cnt_max);
            r_cnt  <= (r_cnt == c_cnt_max) ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= 1'b0;
        end else if (!blink) begin
            r_phase <= 1'b0;
        end else if (r_tick) begin
            r_phase <= ~r_phase;
        end
    end

    // A load on a tick edge wins; that tick's rotation is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf   <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_buf   <= din;
            r_valid <= 1'b1;
        end else if (r_tick && scroll) begin
            r_buf   <= w_rot;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_leds <= '1;
        end else if (!r_valid || r_phase) begin
            r_leds <= '1;
        end else begin
            r_leds <= w_dec;
        end
    end

    assign hex_leds = r_leds;
    assign tick     = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_display_ctrl
// Description : Scoreboard bench for seg7_display_ctrl (4 digits, tick every 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_display_ctrl;

    localparam int NUM_DIGITS = 4;
    localparam int TICK_DIV   = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] din = '0;
    logic        glyph_mode = 1'b0;
    logic        blink = 1'b0;
    logic        scroll = 1'b0;
    logic [27:0] hex_leds;
    logic        tick;

    logic [27:0] exp_q[$];
    logic [27:0] exp_v;
    int          checks = 0;
    int          errors = 0;

    localparam logic [27:0] BLANK = 28'hFFFFFFF;

    seg7_display_ctrl #(.NUM_DIGITS(NUM_DIGITS), .TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .din(din),
        .glyph_mode(glyph_mode), .blink(blink), .scroll(scroll),
        .hex_leds(hex_leds), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] seg4(input logic [6:0] d3, input logic [6:0] d2,
                                         input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        din  = v;
        step();
        load = 1'b0;
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (tick) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_tick: got no tick within 20 cycles, expected one every %0d", TICK_DIV);
        end
    endtask

    task automatic test_reset();
        int bad_leds = 0;
        int first = -1;
        int last = -1;
        int gap_err = 0;
        int nticks = 0;
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (hex_leds !== BLANK || tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: leds=%h tick=%b, expected %h tick=0", hex_leds, tick, BLANK);
        end
        reset_n = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            step();
            if (hex_leds !== BLANK) bad_leds++;
            if (tick === 1'b1) begin
                nticks++;
                if (first < 0) first = c;
                else if (c - last != TICK_DIV) gap_err++;
                last = c;
            end
        end
        checks++;
        if (bad_leds != 0) begin
            errors++;
            $display("FAIL idle_blank: %0d cycles not all-ones, expected 0", bad_leds);
        end
        checks++;
        if (first != TICK_DIV) begin
            errors++;
            $display("FAIL first_tick: at cycle %0d, expected %0d", first, TICK_DIV);
        end
        checks++;
        if (gap_err != 0 || nticks != 100 / TICK_DIV) begin
            errors++;
            $display("FAIL tick_period: %0d ticks, %0d bad gaps, expected %0d ticks, 0 bad gaps",
                     nticks, gap_err, 100 / TICK_DIV);
        end
    endtask

    task automatic test_hex();
        logic [15:0] vals[3] = '{16'h12AF, 16'hBCDE, 16'h0789};
        logic [27:0] exps[3];
        exps[0] = seg4(7'h79, 7'h24, 7'h08, 7'h0E);
        exps[1] = seg4(7'h03, 7'h46, 7'h21, 7'h06);
        exps[2] = seg4(7'h40, 7'h78, 7'h00, 7'h10);
        glyph_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exps[i]);
            do_load(vals[i]);
            step();
            exp_v = exp_q.pop_front();
            checks++;
            if (hex_leds !== exp_v) begin
                errors++;
                $display("FAIL hex_%0d: din=%h leds=%h expected %h", i, vals[i], hex_leds, exp_v);
            end
        end
    endtask

    task automatic test_glyph();
        glyph_mode = 1'b1;
        exp_q.push_back(seg4(7'h79, 7'h24, 7'h11, 7'h7F));
        do_load(16'h12AF);
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (hex_leds !== exp_v) begin
            errors++;
            $display("FAIL glyph_12AF: leds=%h expected %h", hex_leds, exp_v);
        end
        exp_q.push_back(seg4(7'h11, 7'h7B, 7'h2B, 7'h7B));
        do_load(16'hABCB);
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (hex_leds !== exp_v) begin
            errors++;
            $display("FAIL glyph_ABCB: leds=%h expected %h", hex_leds, exp_v);
        end
        // mode change without reload
        glyph_mode = 1'b0;
        exp_q.push_back(seg4(7'h08, 7'h03, 7'h46, 7'h03));
        step();
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (hex_leds !== exp_v) begin
            errors++;
            $display("FAIL glyph_to_hex: leds=%h expected %h", hex_leds, exp_v);
        end
    endtask

    task automatic test_lzb();
`ifdef SEG7_LZB_EN
        exp_q.push_back(seg4(7'h7F, 7'h7F, 7'h12, 7'h40));
        exp_q.push_back(seg4(7'h7F, 7'h7F, 7'h7F, 7'h40));
`else
        exp_q.push_back(seg4(7'h40, 7'h40, 7'h12, 7'h40));
        exp_q.push_back(seg4(7'h40, 7'h40, 7'h40, 7'h40));
`endif
        do_load(16'h0050);
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (hex_leds !== exp_v) begin
            errors++;
            $display("FAIL lzb_0050: leds=%h expected %h", hex_leds, exp_v);
        end
        do_load(16'h0000);
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (hex_leds !== exp_v) begin
            errors++;
            $display("FAIL lzb_0000: leds=%h expected %h", hex_leds, exp_v);
        end
    endtask

    task automatic test_scroll();
        logic [15:0] seq[4] = '{16'h2341, 16'h3412, 16'h4123, 16'h1234};
        logic [6:0]  h[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        exp_q.push_back(seg4(7'h79, 7'h24, 7'h30, 7'h19));
        do_load(16'h1234);
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (hex_leds !== exp_v) begin
            errors++;
            $display("FAIL scroll_load: leds=%h expected %h", hex_leds, exp_v);
        end
        scroll = 1'b1;
        for (int r = 0; r < 4; r++) begin
            exp_q.push_back(seg4(h[seq[r][15:12]], h[seq[r][11:8]], h[seq[r][7:4]], h[seq[r][3:0]]));
            wait_tick();
            step();
            step();
            exp_v = exp_q.pop_front();
            checks++;
            if (hex_leds !== exp_v) begin
                errors++;
                $display("FAIL scroll_rot_%0d: leds=%h expected %h", r + 1, hex_leds, exp_v);
            end
        end
        // load coincides with a rotating tick edge
        exp_q.push_back(seg4(7'h12, 7'h02, 7'h78, 7'h00));
        wait_tick();
        do_load(16'h5678);
        step();
        scroll = 1'b0;
        exp_v = exp_q.pop_front();
        checks++;
        if (hex_leds !== exp_v) begin
            errors++;
            $display("FAIL load_beats_scroll: leds=%h expected %h", hex_leds, exp_v);
        end
    endtask

    task automatic test_blink();
        logic [27:0] shown;
        shown = seg4(7'h79, 7'h24, 7'h30, 7'h19);
        exp_q.push_back(shown);
        do_load(16'h1234);
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (hex_leds !== exp_v) begin
            errors++;
            $display("FAIL blink_load: leds=%h expected %h", hex_leds, exp_v);
        end
        blink = 1'b1;
        for (int p = 0; p < 4; p++) begin
            exp_q.push_back((p % 2 == 0) ? BLANK : shown);
            wait_tick();
            step();
            step();
            exp_v = exp_q.pop_front();
            checks++;
            if (hex_leds !== exp_v) begin
                errors++;
                $display("FAIL blink_phase_%0d: leds=%h expected %h", p, hex_leds, exp_v);
            end
        end
        // drop blink while the blank phase is active
        exp_q.push_back(BLANK);
        exp_q.push_back(shown);
        wait_tick();
        step();
        blink = 1'b0;
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (hex_leds !== exp_v) begin
            errors++;
            $display("FAIL blink_drop_first: leds=%h expected %h", hex_leds, exp_v);
        end
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (hex_leds !== exp_v) begin
            errors++;
            $display("FAIL blink_drop_restore: leds=%h expected %h", hex_leds, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        blink  = 1'b1;
        scroll = 1'b1;
        wait_tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (hex_leds !== BLANK || tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: leds=%h tick=%b expected %h tick=0", hex_leds, tick, BLANK);
        end
        blink  = 1'b0;
        scroll = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        c = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (tick === 1'b1) begin
                c = k;
                break;
            end
        end
        checks++;
        if (c != TICK_DIV) begin
            errors++;
            $display("FAIL restart_tick: first tick at cycle %0d, expected %0d", c, TICK_DIV);
        end
        checks++;
        if (hex_leds !== BLANK) begin
            errors++;
            $display("FAIL restart_invalid: leds=%h expected %h", hex_leds, BLANK);
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_glyph();
        test_lzb();
        test_scroll();
        test_blink();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
